// File: rtl/com_input_filter_if.sv
// Signal bundle between the raw command connector side and the filter.
// The test/host side drives the raw lines and ack; the filter drives the conditioned outputs.
interface com_input_filter_if #(
  parameter int N_CH = 16
);
  logic [N_CH-1:0] iComRaw;
  logic            iAck;
  logic [N_CH-1:0] oCom;
  logic [N_CH-1:0] oChg;
  logic            oEvent;
  logic            oTick;

  modport master (
    output iComRaw,
    output iAck,
    input  oCom,
    input  oChg,
    input  oEvent,
    input  oTick
  );

  modport slave (
    input  iComRaw,
    input  iAck,
    output oCom,
    output oChg,
    output oEvent,
    output oTick
  );
endinterface

// File: rtl/com_input_filter.sv
// Per-channel synchroniser + up/down integrator debounce with hysteresis for the
// raw optocoupler command lines, plus sticky change flags for firmware polling.
module com_input_filter #(
  parameter int N_CH           = 16,
  parameter int RAW_ACTIVE_LOW = 1,
  parameter int TICK_DIV       = 200,
  parameter int FILTER_TICKS   = 10
) (
  input  logic               clk,
  input  logic               aclr,
  com_input_filter_if.slave  bus
);

  localparam int              CNT_W     = $clog2(FILTER_TICKS + 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(FILTER_TICKS);
  localparam logic [15:0]     DIV_LAST  = 16'(TICK_DIV - 1);
  // Synchroniser idles at the raw inactive level so s[] reads 0 out of reset.
  localparam logic [N_CH-1:0] SYNC_IDLE = (RAW_ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

  logic [N_CH-1:0]  sync1_q, sync2_q;
  logic [N_CH-1:0]  s;
  logic [15:0]      div_q, div_d;
  logic             tick;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  com_q, com_d;
  logic [N_CH-1:0]  chg_q, chg_d;
  logic             evt_q, evt_d;

  // Stage 1: two-flop synchroniser and polarity correction
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      sync1_q <= SYNC_IDLE;
      sync2_q <= SYNC_IDLE;
    end else begin
      sync1_q <= bus.iComRaw;
      sync2_q <= sync1_q;
    end
  end

  assign s = (RAW_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  // Stage 2: tick prescaler
  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? 16'd0 : div_q + 16'd1;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) div_q <= 16'd0;
    else      div_q <= div_d;
  end

  // Stage 3: saturating integrators, hysteresis output and sticky flags
  always_comb begin
    com_d = com_q;
    for (int i = 0; i < N_CH; i++) begin
      logic [CNT_W-1:0] nxt;
      nxt = cnt_q[i];
      if (tick) begin
        if (s[i] && (cnt_q[i] != FULL))
          nxt = cnt_q[i] + CNT_W'(1);
        else if (!s[i] && (cnt_q[i] != '0))
          nxt = cnt_q[i] - CNT_W'(1);
        if (nxt == FULL)     com_d[i] = 1'b1;
        else if (nxt == '0)  com_d[i] = 1'b0;
      end
      cnt_d[i] = nxt;
    end
    // A fresh change beats a coincident ack for its own bit.
    chg_d = (bus.iAck ? {N_CH{1'b0}} : chg_q) | (com_d ^ com_q);
    evt_d = |chg_d;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      com_q <= '0;
      chg_q <= '0;
      evt_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      com_q <= com_d;
      chg_q <= chg_d;
      evt_q <= evt_d;
    end
  end

  assign bus.oCom   = com_q;
  assign bus.oChg   = chg_q;
  assign bus.oEvent = evt_q;
  assign bus.oTick  = tick;

endmodule

// File: tb/tb_com_input_filter.sv
// Bench for com_input_filter: directed scenarios plus random traffic, all outputs
// compared every cycle against a behavioural model of the filter rules.
module tb_com_input_filter;
  localparam int N_CH = 16;
  localparam int TD   = 4;
  localparam int FT   = 3;

  logic clk  = 1'b0;
  logic aclr = 1'b0;

  com_input_filter_if #(.N_CH(N_CH)) bus ();

  com_input_filter #(
    .N_CH(N_CH), .RAW_ACTIVE_LOW(1), .TICK_DIV(TD), .FILTER_TICKS(FT)
  ) dut (
    .clk(clk),
    .aclr(aclr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: raw history (two edges deep), edge count since reset,
  // integrator values and the filtered/flag outputs.
  logic [15:0] m_h1, m_h2, m_com, m_chg;
  int          m_cnt [N_CH];
  int          m_ncyc;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_h1   = 16'hFFFF;
    m_h2   = 16'hFFFF;
    m_com  = '0;
    m_chg  = '0;
    m_ncyc = 0;
    for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
  endfunction

  function automatic void m_edge(input logic [15:0] raw, input logic ack);
    logic [15:0] sv;
    logic [15:0] newcom;
    sv     = ~m_h2;
    newcom = m_com;
    if (m_ncyc % TD == TD - 1) begin
      for (int i = 0; i < N_CH; i++) begin
        if (sv[i] && m_cnt[i] < FT)       m_cnt[i] = m_cnt[i] + 1;
        else if (!sv[i] && m_cnt[i] > 0)  m_cnt[i] = m_cnt[i] - 1;
        if (m_cnt[i] == FT)      newcom[i] = 1'b1;
        else if (m_cnt[i] == 0)  newcom[i] = 1'b0;
      end
    end
    m_chg  = (ack ? 16'h0000 : m_chg) | (newcom ^ m_com);
    m_com  = newcom;
    m_h2   = m_h1;
    m_h1   = raw;
    m_ncyc = m_ncyc + 1;
  endfunction

  // One clock: advance the model at the rising edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    if (aclr) m_reset();
    else      m_edge(bus.iComRaw, bus.iAck);
    @(negedge clk);
    chk_eq("oCom",   bus.oCom,   m_com);
    chk_eq("oChg",   bus.oChg,   m_chg);
    chk_eq("oEvent", bus.oEvent, |m_chg);
    chk_eq("oTick",  bus.oTick,  (m_ncyc % TD == TD - 1));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    aclr = 1'b1;
    #1;
    m_reset();
    chk_eq("rst_oCom",   bus.oCom,   16'h0000);
    chk_eq("rst_oChg",   bus.oChg,   16'h0000);
    chk_eq("rst_oEvent", bus.oEvent, 1'b0);
    chk_eq("rst_oTick",  bus.oTick,  1'b0);
    step();
    step();
    aclr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int n;
    bit hit;
    bus.iComRaw = 16'hFFFF;
    bus.iAck    = 1'b0;
    m_reset();

    // 1. reset and idle, tick cadence
    apply_reset();
    for (int k = 1; k <= 12; k++) begin
      step();
      chk_eq("t1_tick", bus.oTick, (k % 4 == 3));
    end
    chk_eq("t1_com", bus.oCom, 16'h0000);

    // 2. clean assert on ch0
    bus.iComRaw[0] = 1'b0;
    lat = 0;
    while (bus.oCom[0] !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk_eq("t2_lat", (lat >= 2 && lat <= 14), 1'b1);
    chk_eq("t2_com", bus.oCom, 16'h0001);
    chk_eq("t2_chg", bus.oChg, 16'h0001);
    chk_eq("t2_evt", bus.oEvent, 1'b1);

    // 3. one-tick glitch on ch5 is rejected
    bus.iComRaw[5] = 1'b0;
    repeat (4) step();
    bus.iComRaw[5] = 1'b1;
    repeat (20) begin
      step();
      chk_eq("t3_com5", bus.oCom[5], 1'b0);
      chk_eq("t3_chg5", bus.oChg[5], 1'b0);
    end

    // 4. hysteresis on ch3
    bus.iComRaw[3] = 1'b0;
    lat = 0;
    while (bus.oCom[3] !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk_eq("t4_rise", bus.oCom[3], 1'b1);
    for (int t = 0; t < 8; t++) begin
      bus.iComRaw[3] = (t % 2 == 0);
      repeat (TD) begin
        step();
        chk_eq("t4_hold", bus.oCom[3], 1'b1);
      end
    end
    bus.iComRaw[3] = 1'b1;
    lat = 0;
    while (bus.oCom[3] !== 1'b0 && lat < 30) begin
      step();
      lat++;
    end
    chk_eq("t4_fall", bus.oCom[3], 1'b0);

    // 5. flag handshake
    chk_eq("t5_pre", bus.oChg, 16'h0009);
    bus.iAck = 1'b1;
    step();
    bus.iAck = 1'b0;
    chk_eq("t5_ack_chg", bus.oChg, 16'h0000);
    chk_eq("t5_ack_evt", bus.oEvent, 1'b0);
    bus.iComRaw[7] = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      if ((m_ncyc % TD == TD - 1) && !m_h2[7] && m_cnt[7] == FT - 1) begin
        bus.iAck = 1'b1;
        step();
        bus.iAck = 1'b0;
        hit = 1'b1;
      end else begin
        step();
      end
    end
    chk_eq("t5_hit", hit, 1'b1);
    chk_eq("t5_coin_chg", bus.oChg, 16'h0080);
    chk_eq("t5_coin_evt", bus.oEvent, 1'b1);

    // 6. reset mid-operation
    apply_reset();
    bus.iComRaw = 16'h0000;
    n = 0;
    while (m_cnt[0] != 2 && n < 30) begin
      step();
      n++;
    end
    #2;
    aclr = 1'b1;
    #1;
    m_reset();
    chk_eq("t6_rst_com", bus.oCom,   16'h0000);
    chk_eq("t6_rst_chg", bus.oChg,   16'h0000);
    chk_eq("t6_rst_evt", bus.oEvent, 1'b0);
    chk_eq("t6_rst_tck", bus.oTick,  1'b0);
    step();
    aclr = 1'b0;
    n = 0;
    while (bus.oCom !== 16'hFFFF && n < 30) begin
      step();
      n++;
    end
    chk_eq("t6_edges", n, 12);

    // random traffic
    bus.iComRaw = 16'hFFFF;
    repeat (40) step();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int ch;
        ch = $urandom_range(0, N_CH - 1);
        bus.iComRaw[ch] = ~bus.iComRaw[ch];
      end
      bus.iAck = ($urandom_range(0, 15) == 0);
      step();
    end
    bus.iAck = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
